// File: rtl/dstream_rr_arbiter_pkg.sv
// rtl/dstream_rr_arbiter_pkg.sv - shared types and constants for the burst round-robin stream arbiter
//
// Holds the arbiter state encoding and the beat-counter width derivation so
// the top level and any future siblings agree on both.

package dstream_rr_arbiter_pkg;

    // IDLE: no requester owns the output. OWN: one requester holds a burst.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int DEFAULT_BURST = 4;

    // The counter has to hold values 1..burst, so it needs clog2(burst+1) bits.
    function automatic int cnt_width(input int burst);
        return (burst < 2) ? 1 : $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/dstream_rr_arbiter_if.sv
// rtl/dstream_rr_arbiter_if.sv - valid/ready/data stream interface used for the arbiter output
//
// Signals:
//   valid - producer has a beat on data
//   ready - consumer accepts the beat this cycle
//   data  - N-bit payload
// Modports:
//   out  - producer side (drives valid/data, samples ready)
//   sink - consumer side (samples valid/data, drives ready)

interface dstream #(
    parameter int N = 16
) ();
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    modport out  (output valid, output data, input ready);
    modport sink (input valid, input data, output ready);
endinterface

// File: rtl/dstream_rr_arbiter_rr_select.sv
// rtl/dstream_rr_arbiter_rr_select.sv - combinational round-robin picker
//
// Ports:
//   req_i   - request vector, one bit per requester
//   start_i - index searched first; search proceeds upward and wraps
//   gnt_o   - one-hot grant of the first asserted request found
//   idx_o   - binary index of that request
//   any_o   - at least one request is asserted

module rr_select #(
    parameter int NUM_IN = 4,
    parameter int IW     = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IW-1:0]     start_i,
    output logic [NUM_IN-1:0] gnt_o,
    output logic [IW-1:0]     idx_o,
    output logic              any_o
);

    int pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            // Explicit wrap instead of a modulo so non-power-of-two NUM_IN works.
            pos = int'(start_i) + k;
            if (pos >= NUM_IN) begin
                pos = pos - NUM_IN;
            end
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                idx_o      = IW'(pos);
                gnt_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dstream_rr_arbiter.sv
// rtl/dstream_rr_arbiter.sv - burst round-robin arbiter merging NUM_IN streams into one
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   reset    - synchronous active-high reset
//   in_valid - per-requester valid
//   in_ready - per-requester ready, at most one bit high
//   in_data  - per-requester payload, packed NUM_IN x N
//   out      - merged output stream (dstream.out)
//   out_src  - requester index of the beat on out.data, meaningful while out.valid

module dstream_rr_arbiter
    import dstream_rr_arbiter_pkg::*;
#(
    parameter  int N      = 16,
    parameter  int NUM_IN = 4,
    parameter  int BURST  = DEFAULT_BURST,
    localparam int IW     = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN-1:0][N-1:0] in_data,
    dstream.out                      out,
    output logic [IW-1:0]            out_src
);

    localparam int CNT_W = cnt_width(BURST);

    arb_state_e    state_q;
    logic [IW-1:0] last_q;      // current owner while OWN, previous owner while IDLE
    logic [CNT_W-1:0] cnt_q;    // beats granted to the owner in the current burst

    logic          out_valid_q;
    logic [N-1:0]  out_data_q;
    logic [IW-1:0] out_src_q;

    logic              load;
    logic              keep_owner;
    logic              accept;
    logic [IW-1:0]     start;
    logic [IW-1:0]     sel_idx;
    logic [NUM_IN-1:0] rr_gnt;
    logic [IW-1:0]     rr_idx;
    logic              rr_any;

    // The single output register may be refilled when empty or draining.
    assign load = !out_valid_q || out.ready;

    assign start = (last_q == IW'(NUM_IN - 1)) ? '0 : last_q + 1'b1;

    rr_select #(
        .NUM_IN (NUM_IN),
        .IW     (IW)
    ) u_rr_select (
        .req_i   (in_valid),
        .start_i (start),
        .gnt_o   (rr_gnt),
        .idx_o   (rr_idx),
        .any_o   (rr_any)
    );

    // The owner keeps the grant only while it still has a beat and burst budget;
    // otherwise the search moves on, so a dropped owner costs no bubble.
    assign keep_owner = (state_q == OWN) && in_valid[last_q] && (cnt_q < CNT_W'(BURST));
    assign sel_idx    = keep_owner ? last_q : rr_idx;
    assign accept     = load && !reset && (keep_owner || rr_any);

    always_comb begin
        in_ready = '0;
        if (accept) begin
            if (keep_owner) begin
                in_ready[last_q] = 1'b1;
            end else begin
                in_ready = rr_gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= IW'(NUM_IN - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else if (load) begin
            out_valid_q <= accept;
            if (accept) begin
                out_data_q <= in_data[sel_idx];
                out_src_q  <= sel_idx;
                state_q    <= OWN;
                last_q     <= sel_idx;
                cnt_q      <= keep_owner ? cnt_q + 1'b1 : CNT_W'(1);
            end else begin
                // Nobody valid: drop ownership but keep last_q so fairness resumes
                // from the same point.
                state_q <= IDLE;
                cnt_q   <= '0;
            end
        end
    end

    assign out.valid = out_valid_q;
    assign out.data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/dstream_rr_arbiter.md
DSTREAM_RR_ARBITER -- requirements
Module: dstream_rr_arbiter

Interface
REQ-001 Parameter N, default 16: data width of every stream.
REQ-002 Parameter NUM_IN, default 4: number of requesting input streams, range 2..8.
REQ-003 Parameter BURST, default 4: maximum consecutive beats granted to one requester, range 1..255.
REQ-004 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, NUM_IN bits: per-requester valid.
REQ-007 Port in_ready, output, NUM_IN bits: per-requester ready.
REQ-008 Port in_data, input, NUM_IN x N bits (packed array): per-requester data.
REQ-009 Port out, dstream.out modport, N-bit data: shared downstream stream.
REQ-010 Port out_src, output, $clog2(NUM_IN) bits: index of the requester whose beat is on out.data, valid when out.valid.

Function
REQ-011 A beat transfers on any stream only in a cycle where valid and ready are both high; the block SHALL hold out.valid, out.data and out_src stable while out.valid=1 and out.ready=0.
REQ-012 The block SHALL contain one output register (data, src, valid); "load" is true when out.valid=0 or out.ready=1.
REQ-013 in_ready[i] SHALL be high only when load=1, in_valid[i]=1 and i is the selected requester; at most one in_ready bit is high per cycle.
REQ-014 Latency SHALL be 1 cycle: a beat accepted on input i in cycle t appears on out in cycle t+1 with out_src=i.
REQ-015 Sustained throughput SHALL be one beat per cycle when out.ready is held high and any in_valid is high.
REQ-016 States: IDLE (no owner) and OWN (owner index, beat counter 1..BURST).
REQ-017 Selection in IDLE, or in OWN when the owner has dropped valid or the counter has reached BURST: the first asserted in_valid searching upward from (last owner + 1), wrapping modulo NUM_IN.
REQ-018 In OWN, with owner valid and counter < BURST, the owner SHALL be reselected and the counter incremented per accepted beat.
REQ-019 A new grant SHALL set the counter to 1 and the owner to the selected index; no asserted in_valid -> IDLE, last-owner pointer unchanged.
REQ-020 When load=0 no selection, counter or owner change SHALL occur.
REQ-021 BURST=1 SHALL degenerate to pure per-beat round robin.
REQ-022 Owner deasserting valid mid-burst SHALL forfeit the rest of its burst without a bubble if another requester is valid in the same cycle.
REQ-023 A lone requester SHALL be regranted immediately after its burst expires (no idle cycle).

Reset
REQ-024 During reset: out.valid=0, in_ready=0, out.data=0, out_src=0, state=IDLE, counter=0, last-owner pointer=NUM_IN-1 (so requester 0 has first priority).
REQ-025 Reset asserted mid-burst or with a beat pending on out SHALL discard that beat; no beat SHALL be accepted in a reset cycle.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, OWN) and the counter width constant derived from BURST.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_select (inputs request vector, start pointer; outputs one-hot grant, index, any).

Verification
REQ-028 After reset, in_valid=4'b1111, out.ready=1, BURST=4 -> out_src sequence 0,0,0,0,1,1,1,1,2,... starting one cycle after the first accept, no gaps.
REQ-029 Backpressure: out.valid=1, out.ready=0 for 5 cycles -> out.data/out_src constant, in_ready=0 throughout; first ready cycle transfers and loads next beat.
REQ-030 Owner 1 drops valid after 2 beats while 3 is valid -> next out_src=3 with no bubble, counter restarts at 1.
REQ-031 Only in_valid[2]=1, BURST=2, out.ready=1 -> continuous beats from src 2 every cycle, never idle.
REQ-032 Reset pulsed with out.valid=1 mid-burst -> next cycle out.valid=0, in_ready=0; after release requester 0 wins if valid.
REQ-033 Random valid/ready with BURST=1 scoreboard -> every input beat appears exactly once, in order per source, no source starved >NUM_IN-1 grants.
